// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry arbiter: FSM state encoding,
// lane identifiers, default sizing and the lockout threshold.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT_RESULT,
    WAIT_CLOSE
  } state_t;

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_t;

  localparam int DEF_CAPACITY   = 8;
  localparam int DEF_TIMEOUT    = 16;
  localparam int LOCK_THRESHOLD = 3;

  function automatic lane_t other_lane(input lane_t l);
    return (l == LANE_A) ? LANE_B : LANE_A;
  endfunction

endpackage

// File: rtl/parking_entry_arbiter_if.sv
// Link between the arbiter and the shared parking access controller:
// password strobe/value towards the controller, gate outcome back.
interface parking_entry_arbiter_if;

  logic       try_psswrd_o;
  logic [7:0] psswrd_atmpt_o;
  logic       gate_open_i;
  logic       gate_alarm_i;
  logic       gate_closed_i;

  modport master (
    output try_psswrd_o,
    output psswrd_atmpt_o,
    input  gate_open_i,
    input  gate_alarm_i,
    input  gate_closed_i
  );

  modport slave (
    input  try_psswrd_o,
    input  psswrd_atmpt_o,
    output gate_open_i,
    output gate_alarm_i,
    output gate_closed_i
  );

endinterface

// File: rtl/occupancy_counter.sv
// Lot occupancy: saturating up/down counter. A simultaneous entry and exit
// cancel out; exits never take the count below zero.
module occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

  // Count register, saturating at both ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != CAP_V) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign full = (count == CAP_V);

endmodule

// File: rtl/parking_entry_arbiter.sv
// Round-robin arbiter sharing one parking access controller between entry
// lanes A and B. Optional macro LANE_LOCKOUT_EN adds per-lane lockout after
// three consecutive rejects, with lock_a/lock_b outputs and an unlock input.
module parking_entry_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TO_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_a,
  input  logic                   req_b,
  input  logic [7:0]             psswrd_a,
  input  logic [7:0]             psswrd_b,
  input  logic                   car_exit,
  parking_entry_arbiter_if.master ctrl,
  output logic                   grant_a,
  output logic                   grant_b,
  output logic                   done_a,
  output logic                   done_b,
  output logic                   reject_a,
  output logic                   reject_b,
  output logic                   full,
  output logic [CNT_W-1:0]       occupancy
`ifdef LANE_LOCKOUT_EN
  ,
  input  logic                   unlock,
  output logic                   lock_a,
  output logic                   lock_b
`endif
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, next_state;
  lane_t           owner, rr_ptr, winner;
  logic [7:0]      pw_latch;
  logic [TO_W-1:0] to_cnt;
  logic            load, finish_ok, finish_rej;
  logic            eff_a, eff_b;
  logic            lock_mask_a, lock_mask_b;
  logic            active;

  // A lane whose done/reject is pulsing is still holding its request this
  // cycle, so it is masked to avoid re-granting a finished session.
  assign eff_a = req_a && !done_a && !reject_a && !lock_mask_a;
  assign eff_b = req_b && !done_b && !reject_b && !lock_mask_b;

  // Next-state and transaction control
  always_comb begin
    next_state = state;
    load       = 1'b0;
    winner     = rr_ptr;
    finish_ok  = 1'b0;
    finish_rej = 1'b0;
    case (state)
      IDLE: begin
        if (!full && (eff_a || eff_b)) begin
          load       = 1'b1;
          next_state = GRANT;
          if (eff_a && eff_b) winner = rr_ptr;
          else if (eff_a)     winner = LANE_A;
          else                winner = LANE_B;
        end
      end
      GRANT: next_state = ISSUE;
      ISSUE: next_state = WAIT_RESULT;
      WAIT_RESULT: begin
        if (ctrl.gate_alarm_i) begin
          finish_rej = 1'b1;
          next_state = IDLE;
        end else if (ctrl.gate_open_i) begin
          next_state = WAIT_CLOSE;
        end else if (to_cnt == TO_LAST) begin
          finish_rej = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_CLOSE: begin
        if (ctrl.gate_closed_i) begin
          finish_ok  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, session ownership, timeout counter, pointer and result pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= LANE_A;
      rr_ptr   <= LANE_A;
      pw_latch <= 8'h00;
      to_cnt   <= '0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      reject_a <= 1'b0;
      reject_b <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        owner    <= winner;
        pw_latch <= (winner == LANE_A) ? psswrd_a : psswrd_b;
      end
      if (state == ISSUE)            to_cnt <= '0;
      else if (state == WAIT_RESULT) to_cnt <= to_cnt + 1'b1;
      if (finish_ok || finish_rej) rr_ptr <= other_lane(rr_ptr);
      done_a   <= finish_ok  && (owner == LANE_A);
      done_b   <= finish_ok  && (owner == LANE_B);
      reject_a <= finish_rej && (owner == LANE_A);
      reject_b <= finish_rej && (owner == LANE_B);
    end
  end

  assign active              = (state != IDLE);
  assign grant_a             = active && (owner == LANE_A);
  assign grant_b             = active && (owner == LANE_B);
  assign ctrl.try_psswrd_o   = (state == ISSUE);
  assign ctrl.psswrd_atmpt_o = active ? pw_latch : 8'h00;

  occupancy_counter #(
    .CAPACITY(CAPACITY),
    .CNT_W   (CNT_W)
  ) u_occ (
    .clk  (clk),
    .rst  (rst),
    .inc  (finish_ok),
    .dec  (car_exit),
    .count(occupancy),
    .full (full)
  );

`ifdef LANE_LOCKOUT_EN
  localparam logic [1:0] LOCK_LAST = 2'(LOCK_THRESHOLD - 1);

  logic [1:0] rej_cnt_a, rej_cnt_b;
  logic       lock_a_q, lock_b_q;

  // Consecutive-reject tracking per lane; unlock clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rej_cnt_a <= 2'd0;
      rej_cnt_b <= 2'd0;
      lock_a_q  <= 1'b0;
      lock_b_q  <= 1'b0;
    end else if (unlock) begin
      rej_cnt_a <= 2'd0;
      rej_cnt_b <= 2'd0;
      lock_a_q  <= 1'b0;
      lock_b_q  <= 1'b0;
    end else begin
      if (finish_ok && owner == LANE_A) begin
        rej_cnt_a <= 2'd0;
      end else if (finish_rej && owner == LANE_A) begin
        if (rej_cnt_a == LOCK_LAST) lock_a_q <= 1'b1;
        if (rej_cnt_a != 2'd3)      rej_cnt_a <= rej_cnt_a + 1'b1;
      end
      if (finish_ok && owner == LANE_B) begin
        rej_cnt_b <= 2'd0;
      end else if (finish_rej && owner == LANE_B) begin
        if (rej_cnt_b == LOCK_LAST) lock_b_q <= 1'b1;
        if (rej_cnt_b != 2'd3)      rej_cnt_b <= rej_cnt_b + 1'b1;
      end
    end
  end

  assign lock_a      = lock_a_q;
  assign lock_b      = lock_b_q;
  assign lock_mask_a = lock_a_q;
  assign lock_mask_b = lock_b_q;
`else
  assign lock_mask_a = 1'b0;
  assign lock_mask_b = 1'b0;
`endif

endmodule

// File: tb/tb_parking_entry_arbiter.sv
// Self-checking bench for parking_entry_arbiter: a cycle table for a full
// lane-A session followed by hand-written multi-cycle scenarios.
module tb_parking_entry_arbiter;

  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  typedef struct {
    logic       req_a;
    logic       req_b;
    logic [7:0] pa;
    logic [7:0] pb;
    logic       ce;
    logic       go;
    logic       gal;
    logic       gc;
    logic [19:0] exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req_a, req_b;
  logic [7:0] psswrd_a, psswrd_b;
  logic       car_exit;
  logic       grant_a, grant_b, done_a, done_b, reject_a, reject_b, full;
  logic [3:0] occupancy;
`ifdef LANE_LOCKOUT_EN
  logic       unlock;
  logic       lock_a, lock_b;
`endif

  int checks = 0;
  int errors = 0;

  vec_t vecs[13];

  parking_entry_arbiter_if ctrl_bus();

  parking_entry_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .psswrd_a (psswrd_a),
    .psswrd_b (psswrd_b),
    .car_exit (car_exit),
    .ctrl     (ctrl_bus),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .done_a   (done_a),
    .done_b   (done_b),
    .reject_a (reject_a),
    .reject_b (reject_b),
    .full     (full),
    .occupancy(occupancy)
`ifdef LANE_LOCKOUT_EN
    ,
    .unlock   (unlock),
    .lock_a   (lock_a),
    .lock_b   (lock_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [19:0] exp_o(bit t, logic [7:0] pw, bit ga, bit gb,
                                        bit da, bit db, bit ra, bit rb,
                                        bit fl, logic [3:0] occ);
    return {t, pw, ga, gb, da, db, ra, rb, fl, occ};
  endfunction

  function automatic logic [19:0] pack_out();
    return {ctrl_bus.try_psswrd_o, ctrl_bus.psswrd_atmpt_o, grant_a, grant_b,
            done_a, done_b, reject_a, reject_b, full, occupancy};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_a                  = v.req_a;
    req_b                  = v.req_b;
    psswrd_a               = v.pa;
    psswrd_b               = v.pb;
    car_exit               = v.ce;
    ctrl_bus.gate_open_i   = v.go;
    ctrl_bus.gate_alarm_i  = v.gal;
    ctrl_bus.gate_closed_i = v.gc;
  endtask

  task automatic idle_inputs();
    req_a                  = 1'b0;
    req_b                  = 1'b0;
    psswrd_a               = 8'h00;
    psswrd_b               = 8'h00;
    car_exit               = 1'b0;
    ctrl_bus.gate_open_i   = 1'b0;
    ctrl_bus.gate_alarm_i  = 1'b0;
    ctrl_bus.gate_closed_i = 1'b0;
`ifdef LANE_LOCKOUT_EN
    unlock                 = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Waits (bounded) for the try strobe; returns sampled #1 after a negedge.
  task automatic wait_try(input string name);
    int t;
    t = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (ctrl_bus.try_psswrd_o) begin
        t = k;
        break;
      end
    end
    checkOutput(name, 32'(t >= 0), 32'd1);
  endtask

  // Controller answer 'delay' cycles after the try cycle.
  task automatic ctrl_reply(input int delay, input bit op, input bit al);
    repeat (delay) @(negedge clk);
    ctrl_bus.gate_open_i  = op;
    ctrl_bus.gate_alarm_i = al;
    @(negedge clk);
    ctrl_bus.gate_open_i  = 1'b0;
    ctrl_bus.gate_alarm_i = 1'b0;
    #1;
  endtask

  task automatic close_gate(input bit exit_too);
    ctrl_bus.gate_closed_i = 1'b1;
    car_exit               = exit_too;
    @(negedge clk);
    ctrl_bus.gate_closed_i = 1'b0;
    car_exit               = 1'b0;
    #1;
  endtask

  task automatic session_a_ok(input logic [7:0] pw);
    req_a    = 1'b1;
    psswrd_a = pw;
    wait_try("sess_try");
    ctrl_reply(1, 1'b1, 1'b0);
    close_gate(1'b0);
    req_a = 1'b0;
  endtask

  initial begin
    int   lat;
    logic seen;

    // Cycle table: one lane-A session, then an exit plus a lane-B request.
    vecs[0]  = '{I, O, 8'hA5, 8'h00, O, O, O, O, exp_o(O, 8'h00, O, O, O, O, O, O, O, 4'd0)};
    vecs[1]  = '{I, O, 8'hA5, 8'h00, O, O, O, O, exp_o(O, 8'hA5, I, O, O, O, O, O, O, 4'd0)};
    vecs[2]  = '{I, O, 8'hA5, 8'h00, O, O, O, O, exp_o(I, 8'hA5, I, O, O, O, O, O, O, 4'd0)};
    vecs[3]  = '{I, O, 8'hA5, 8'h00, O, O, O, O, exp_o(O, 8'hA5, I, O, O, O, O, O, O, 4'd0)};
    vecs[4]  = '{I, O, 8'hA5, 8'h00, O, O, O, O, exp_o(O, 8'hA5, I, O, O, O, O, O, O, 4'd0)};
    vecs[5]  = '{I, O, 8'hA5, 8'h00, O, I, O, O, exp_o(O, 8'hA5, I, O, O, O, O, O, O, 4'd0)};
    vecs[6]  = '{I, O, 8'hA5, 8'h00, O, O, O, O, exp_o(O, 8'hA5, I, O, O, O, O, O, O, 4'd0)};
    vecs[7]  = '{I, O, 8'hA5, 8'h00, O, O, O, I, exp_o(O, 8'hA5, I, O, O, O, O, O, O, 4'd0)};
    vecs[8]  = '{I, O, 8'hA5, 8'h00, O, O, O, O, exp_o(O, 8'h00, O, O, I, O, O, O, O, 4'd1)};
    vecs[9]  = '{O, O, 8'hA5, 8'h00, O, O, O, O, exp_o(O, 8'h00, O, O, O, O, O, O, O, 4'd1)};
    vecs[10] = '{O, I, 8'hA5, 8'h5A, I, O, O, O, exp_o(O, 8'h00, O, O, O, O, O, O, O, 4'd1)};
    vecs[11] = '{O, I, 8'hA5, 8'h5A, O, O, O, O, exp_o(O, 8'h5A, O, I, O, O, O, O, O, 4'd0)};
    vecs[12] = '{O, I, 8'hA5, 8'h5A, O, O, O, O, exp_o(I, 8'h5A, O, I, O, O, O, O, O, 4'd0)};

    do_reset();
    #1;
    checkOutput("reset_state", 32'(pack_out()), 32'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), 32'(pack_out()), 32'(vecs[i].exp));
    end

    // Simultaneous requests: A, then B, then A again.
    do_reset();
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1; psswrd_a = 8'h11; psswrd_b = 8'h22;
    wait_try("rr_try1");
    checkOutput("rr_grant1", 32'({grant_a, grant_b}), 32'b10);
    checkOutput("rr_pw1", 32'(ctrl_bus.psswrd_atmpt_o), 32'h11);
    ctrl_reply(1, 1'b1, 1'b0);
    close_gate(1'b0);
    checkOutput("rr_done1", 32'({done_a, done_b}), 32'b10);
    req_a = 1'b0;
    wait_try("rr_try2");
    checkOutput("rr_grant2", 32'({grant_a, grant_b}), 32'b01);
    checkOutput("rr_pw2", 32'(ctrl_bus.psswrd_atmpt_o), 32'h22);
    ctrl_reply(2, 1'b1, 1'b0);
    close_gate(1'b0);
    checkOutput("rr_done2", 32'({done_a, done_b}), 32'b01);
    checkOutput("rr_occ", 32'(occupancy), 32'd2);
    req_b = 1'b0;
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1;
    wait_try("rr_try3");
    checkOutput("rr_grant3", 32'({grant_a, grant_b}), 32'b10);
    ctrl_reply(1, 1'b1, 1'b0);
    close_gate(1'b0);
    req_a = 1'b0;
    wait_try("rr_try4");
    checkOutput("rr_grant4", 32'({grant_a, grant_b}), 32'b01);
    ctrl_reply(1, 1'b1, 1'b0);
    close_gate(1'b0);
    req_b = 1'b0;

    // Alarm rejects A, pointer moves to B; alarm beats open in the same cycle.
    do_reset();
    @(negedge clk);
    req_a = 1'b1; psswrd_a = 8'h33;
    wait_try("alarm_try");
    ctrl_reply(2, 1'b0, 1'b1);
    checkOutput("alarm_reject", 32'({reject_a, done_a, grant_a}), 32'b100);
    checkOutput("alarm_occ", 32'(occupancy), 32'd0);
    req_a = 1'b0;
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1; psswrd_b = 8'h44;
    wait_try("alarm_try2");
    checkOutput("alarm_ptr_b", 32'({grant_a, grant_b}), 32'b01);
    ctrl_reply(1, 1'b1, 1'b1);
    checkOutput("alarm_wins", 32'({reject_b, done_b, grant_b}), 32'b100);
    req_a = 1'b0; req_b = 1'b0;

    // Timeout: no controller answer.
    do_reset();
    @(negedge clk);
    req_a = 1'b1;
    wait_try("to_try");
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (reject_a) begin
        lat = k;
        break;
      end
    end
    checkOutput("timeout_latency", 32'(lat), 32'd17);
    req_a = 1'b0;

    // Exit at zero occupancy saturates.
    @(negedge clk);
    car_exit = 1'b1;
    @(negedge clk);
    car_exit = 1'b0;
    #1;
    checkOutput("exit_at_zero", 32'(occupancy), 32'd0);

    // Fill the lot, then a blocked B request is released by one exit.
    do_reset();
    @(negedge clk);
    for (int n = 0; n < 8; n++) session_a_ok(8'(n));
    checkOutput("fill_occ", 32'({full, occupancy}), 32'h18);
    req_b = 1'b1; psswrd_b = 8'h5B;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      seen = seen | grant_a | grant_b | reject_b;
    end
    checkOutput("full_blocks", 32'(seen), 32'd0);
    car_exit = 1'b1;
    @(negedge clk);
    car_exit = 1'b0;
    #1;
    checkOutput("exit_occ", 32'({full, occupancy, grant_b}), 32'({1'b0, 4'd7, 1'b0}));
    @(negedge clk);
    #1;
    checkOutput("exit_grant_b", 32'(grant_b), 32'd1);
    wait_try("full_try");
    ctrl_reply(1, 1'b1, 1'b0);
    close_gate(1'b1);
    checkOutput("inc_dec_same", 32'({done_b, occupancy}), 32'({1'b1, 4'd7}));
    req_b = 1'b0;

    // Reset asserted while waiting for the gate to close.
    @(negedge clk);
    req_a = 1'b1; psswrd_a = 8'h66;
    wait_try("rst_try");
    ctrl_reply(1, 1'b1, 1'b0);
    checkOutput("rst_pre", 32'({grant_a, occupancy}), 32'({1'b1, 4'd7}));
    rst = 1'b0;
    #1;
    checkOutput("rst_mid", 32'(pack_out()), 32'd0);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_after", 32'(pack_out()), 32'd0);

`ifdef LANE_LOCKOUT_EN
    // Three rejects lock lane A until unlock.
    do_reset();
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      req_a = 1'b1;
      wait_try("lock_try");
      ctrl_reply(1, 1'b0, 1'b1);
      req_a = 1'b0;
    end
    checkOutput("lock_set", 32'({lock_a, lock_b}), 32'b10);
    @(negedge clk);
    req_a = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      seen = seen | grant_a;
    end
    checkOutput("lock_ignores", 32'(seen), 32'd0);
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;
    #1;
    checkOutput("unlock_clear", 32'(lock_a), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("unlock_grant", 32'(grant_a), 32'd1);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
